// File: rtl/mem_data_bytewise.sv
// rtl/mem_data_bytewise.sv - byte-addressed MEM-stage data RAM with post-reset clear and debug read port
module mem_data_bytewise #(
    parameter int NB_DATA    = 32,
    parameter int N_ELEMENTS = 256,
    parameter int NB_ADDR    = $clog2(N_ELEMENTS) + 2
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic                          enable_mem_i,
    input  logic [NB_ADDR-1:0]            addr_i,
    input  logic [NB_DATA-1:0]            data_write_i,
    input  logic                          mem_read_i,
    input  logic                          mem_write_i,
    input  logic [1:0]                    size_i,
    input  logic                          unsigned_i,
    output logic [NB_DATA-1:0]            data_o,
    output logic                          misaligned_o,
    output logic                          busy_o,
    input  logic [$clog2(N_ELEMENTS)-1:0] debug_addr_i,
    output logic [NB_DATA-1:0]            debug_data_o
);
    localparam int NB_IDX = $clog2(N_ELEMENTS);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_ELEMENTS - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    logic [NB_DATA-1:0] r_mem [N_ELEMENTS];
    state_t             r_state;
    logic [NB_IDX-1:0]  r_clr_idx;
    logic               r_busy;
    logic [NB_DATA-1:0] r_data;
    logic               r_misaligned;
    logic [NB_DATA-1:0] r_debug_data;

    logic [NB_IDX-1:0]  w_word_idx;
    logic [1:0]         w_lane;
    logic               w_req;
    logic               w_aligned;
    logic               w_rd;
    logic               w_wr;
    logic [NB_DATA-1:0] w_old_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [NB_DATA-1:0] w_load;
    logic               w_ram_we;
    logic [NB_IDX-1:0]  w_ram_idx;
    logic [3:0]         w_ram_be;
    logic [NB_DATA-1:0] w_ram_wdata;

    assign w_word_idx = addr_i[NB_ADDR-1:2];
    assign w_lane     = addr_i[1:0];
    assign w_req      = (r_state == ST_IDLE) & enable_mem_i & (mem_read_i | mem_write_i);
    assign w_rd       = w_req & w_aligned & mem_read_i;
    assign w_wr       = w_req & w_aligned & mem_write_i;
    assign w_old_word = r_mem[w_word_idx];

    always_comb begin
        w_aligned = 1'b1;
        case (size_i)
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~w_lane[0];
            default: w_aligned = (w_lane == 2'b00);
        endcase
    end

    // Load path sees the pre-write word, which gives read-before-write for free.
    always_comb begin
        w_byte = 8'h00;
        case (w_lane)
            2'd0: w_byte = w_old_word[7:0];
            2'd1: w_byte = w_old_word[15:8];
            2'd2: w_byte = w_old_word[23:16];
            2'd3: w_byte = w_old_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = w_lane[1] ? w_old_word[31:16] : w_old_word[15:0];
        w_load = w_old_word;
        case (size_i)
            2'b00:   w_load = {{24{w_byte[7] & ~unsigned_i}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~unsigned_i}}, w_half};
            default: w_load = w_old_word;
        endcase
    end

    // The clear sequencer owns the single write port while it runs.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_idx   = w_word_idx;
        w_ram_be    = 4'b0000;
        w_ram_wdata = data_write_i;
        if (r_state == ST_CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_idx   = r_clr_idx;
            w_ram_be    = 4'b1111;
            w_ram_wdata = '0;
        end else begin
            w_ram_we = w_wr;
            case (size_i)
                2'b00: begin
                    w_ram_be    = 4'b0001 << w_lane;
                    w_ram_wdata = {4{data_write_i[7:0]}};
                end
                2'b01: begin
                    w_ram_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                    w_ram_wdata = {2{data_write_i[15:0]}};
                end
                default: begin
                    w_ram_be    = 4'b1111;
                    w_ram_wdata = data_write_i;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_ram_be[k]) r_mem[w_ram_idx][8*k +: 8] <= w_ram_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_data       <= '0;
            r_misaligned <= 1'b0;
            r_debug_data <= '0;
        end else begin
            if (w_rd) r_data <= w_load;
            r_misaligned <= w_req & ~w_aligned;
            r_debug_data <= r_mem[debug_addr_i];
        end
    end

    assign data_o       = r_data;
    assign misaligned_o = r_misaligned;
    assign busy_o       = r_busy;
    assign debug_data_o = r_debug_data;
endmodule

// File: tb/tb_mem_data_bytewise.sv
// tb/tb_mem_data_bytewise.sv - self-checking bench for mem_data_bytewise
module tb_mem_data_bytewise;
    localparam int N       = 256;
    localparam int NB_ADDR = 10;
    localparam int NB_IDX  = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               rd = 1'b0;
    logic               wr = 1'b0;
    logic               uns = 1'b0;
    logic [1:0]         sz = 2'b00;
    logic [NB_ADDR-1:0] addr = '0;
    logic [31:0]        wdata = '0;
    logic [NB_IDX-1:0]  dbg_addr = '0;
    logic [31:0]        data_o;
    logic               mis_o;
    logic               busy_o;
    logic [31:0]        dbg_o;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_hold = '0;
    logic [31:0] exp_v;

    mem_data_bytewise #(.NB_DATA(32), .N_ELEMENTS(N), .NB_ADDR(NB_ADDR)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .enable_mem_i(en), .addr_i(addr),
        .data_write_i(wdata), .mem_read_i(rd), .mem_write_i(wr), .size_i(sz),
        .unsigned_i(uns), .data_o(data_o), .misaligned_o(mis_o), .busy_o(busy_o),
        .debug_addr_i(dbg_addr), .debug_data_o(dbg_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic u,
                         input logic [NB_ADDR-1:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; rd = r; wr = w; sz = s; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset();
        int cycles;
        repeat (2) @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", busy_o); end
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=00000000", data_o); end
        n_checks++; if (mis_o !== 1'b0) begin n_fail++; $display("FAIL reset_mis got=%b exp=0", mis_o); end
        n_checks++; if (dbg_o !== 32'h0) begin n_fail++; $display("FAIL reset_dbg got=%h exp=00000000", dbg_o); end
        @(negedge clk);
        rst_n = 1'b1;
        cycles = 0;
        while (busy_o === 1'b1 && cycles < 2 * N) begin
            @(posedge clk); #1; cycles++;
        end
        n_checks++; if (cycles != N) begin n_fail++; $display("FAIL clear_cycles got=%0d exp=%0d", cycles, N); end
    endtask

    task automatic test_dump(input string tag);
        for (int i = 0; i < N; i++) begin
            @(negedge clk); dbg_addr = NB_IDX'(i);
            @(posedge clk); #1;
            n_checks++;
            if (dbg_o !== 32'h0) begin
                n_fail++; $display("FAIL dump_%s word=%0d got=%h exp=00000000", tag, i, dbg_o);
            end
        end
    endtask

    task automatic test_loads();
        logic [NB_ADDR-1:0] a_t[5] = '{10'h10, 10'h13, 10'h13, 10'h12, 10'h12};
        logic [1:0]         s_t[5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic               u_t[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0]        e_t[5] = '{32'h0000_0001, 32'hFFFF_FF80, 32'h0000_0080,
                                       32'hFFFF_8081, 32'h0000_8081};
        sb_q.push_back(exp_hold);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 10'h10, 32'h8081_7F01);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL sw_hold got=%h exp=%h", data_o, exp_v); end
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(e_t[i]); exp_hold = e_t[i];
            drive(1'b1, 1'b0, s_t[i], u_t[i], a_t[i], 32'h0);
            exp_v = sb_q.pop_front();
            n_checks++;
            if (data_o !== exp_v) begin n_fail++; $display("FAIL load_%0d got=%h exp=%h", i, data_o, exp_v); end
        end
    endtask

    task automatic test_stores();
        sb_q.push_back(exp_hold);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 10'h11, 32'hFFFF_FFAA);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL sb_hold got=%h exp=%h", data_o, exp_v); end
        sb_q.push_back(32'h8081_AA01); exp_hold = 32'h8081_AA01;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 10'h10, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL lw_after_sb got=%h exp=%h", data_o, exp_v); end
        drive(1'b0, 1'b1, 2'b01, 1'b0, 10'h12, 32'hABCD_1234);
        sb_q.push_back(32'h1234_AA01); exp_hold = 32'h1234_AA01;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 10'h10, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL lw_after_sh got=%h exp=%h", data_o, exp_v); end
    endtask

    task automatic test_misaligned();
        sb_q.push_back(exp_hold);
        drive(1'b1, 1'b0, 2'b01, 1'b0, 10'h11, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (mis_o !== 1'b1) begin n_fail++; $display("FAIL mis_lh got=%b exp=1", mis_o); end
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL mis_lh_hold got=%h exp=%h", data_o, exp_v); end
        sb_q.push_back(exp_hold);
        drive(1'b0, 1'b1, 2'b10, 1'b0, 10'h12, 32'hDEAD_BEEF);
        exp_v = sb_q.pop_front();
        n_checks++; if (mis_o !== 1'b1) begin n_fail++; $display("FAIL mis_sw got=%b exp=1", mis_o); end
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL mis_sw_hold got=%h exp=%h", data_o, exp_v); end
        @(negedge clk); rd = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (mis_o !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end got=%b exp=0", mis_o); end
        sb_q.push_back(32'h1234_AA01); exp_hold = 32'h1234_AA01;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 10'h10, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL mis_word_kept got=%h exp=%h", data_o, exp_v); end
        sb_q.push_back(32'h0000_0012); exp_hold = 32'h0000_0012;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 10'h13, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL lb_odd got=%h exp=%h", data_o, exp_v); end
        n_checks++; if (mis_o !== 1'b0) begin n_fail++; $display("FAIL lb_odd_mis got=%b exp=0", mis_o); end
    endtask

    task automatic test_rbw();
        sb_q.push_back(32'h0); exp_hold = 32'h0;
        drive(1'b1, 1'b1, 2'b10, 1'b0, 10'h20, 32'h5555_5555);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL rbw_old got=%h exp=%h", data_o, exp_v); end
        sb_q.push_back(32'h5555_5555); exp_hold = 32'h5555_5555;
        drive(1'b1, 1'b0, 2'b11, 1'b0, 10'h20, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL rbw_new got=%h exp=%h", data_o, exp_v); end
    endtask

    task automatic test_enable();
        @(negedge clk);
        en = 1'b0; rd = 1'b1; wr = 1'b1; sz = 2'b10; addr = 10'h10; wdata = 32'h0;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; en = 1'b1;
        n_checks++; if (data_o !== exp_hold) begin n_fail++; $display("FAIL en0_hold got=%h exp=%h", data_o, exp_hold); end
        sb_q.push_back(32'h1234_AA01); exp_hold = 32'h1234_AA01;
        drive(1'b1, 1'b0, 2'b10, 1'b0, 10'h10, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL en0_nowrite got=%h exp=%h", data_o, exp_v); end
    endtask

    task automatic test_restart();
        int cycles;
        int bad;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #2;
        exp_hold = 32'h0;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL restart_busy got=%b exp=1", busy_o); end
        n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL restart_data got=%h exp=00000000", data_o); end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; rd = 1'b1; sz = 2'b10; addr = 10'h20;
        cycles = 0; bad = 0;
        while (busy_o === 1'b1 && cycles < 2 * N) begin
            @(posedge clk); #1; cycles++;
            if (data_o !== 32'h0) bad++;
        end
        rd = 1'b0;
        n_checks++; if (cycles != N) begin n_fail++; $display("FAIL restart_cycles got=%0d exp=%0d", cycles, N); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL busy_loads got=%0d nonzero exp=0", bad); end
        sb_q.push_back(32'h0);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 10'h20, 32'h0);
        exp_v = sb_q.pop_front();
        n_checks++; if (data_o !== exp_v) begin n_fail++; $display("FAIL cleared_word got=%h exp=%h", data_o, exp_v); end
    endtask

    initial begin
        test_reset();
        test_dump("initial");
        test_loads();
        test_stores();
        test_misaligned();
        test_rbw();
        test_enable();
        test_restart();
        test_dump("restart");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
